// File: rtl/life_engine.sv
// Registered Game-of-Life engine: cell array, per-cell rules, step/run control.
// Define LIFE_TORUS_EN to wrap the grid edges instead of using a dead border.
module life_engine #(
    parameter int ROWS           = 8,
    parameter int COLS           = 8,
    parameter int PERIOD         = 4,
    parameter int GEN_W          = 16,
    parameter int STOP_ON_STABLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [ROWS*COLS-1:0] seed,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 step,
    output logic [ROWS*COLS-1:0] grid,
    output logic [GEN_W-1:0]     gen_count,
    output logic                 running,
    output logic                 gen_done,
    output logic                 stable,
    output logic                 extinct
);

    localparam int N  = ROWS * COLS;
    localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [TW-1:0]  timer_q;
    logic [TW-1:0]  timer_d;
    logic [N-1:0]   grid_q;
    logic [N-1:0]   nxt;
    logic [GEN_W-1:0] gen_q;
    logic           done_q;
    logic           stable_q;
    logic           evolve;
    logic           timer_last;
    logic           no_change;

    // Neighbour indices are resolved at elaboration; each cell gets its own adder.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [7:0] nb;
            logic [3:0] sum;

            for (genvar k = 0; k < 8; k++) begin : g_nb
                localparam int KK = (k < 4) ? k : k + 1;
                localparam int NR = r + KK / 3 - 1;
                localparam int NC = c + KK % 3 - 1;
`ifdef LIFE_TORUS_EN
                localparam int WR = (NR + ROWS) % ROWS;
                localparam int WC = (NC + COLS) % COLS;
                assign nb[k] = grid_q[WR*COLS+WC];
`else
                if (NR >= 0 && NR < ROWS && NC >= 0 && NC < COLS) begin : g_in
                    assign nb[k] = grid_q[NR*COLS+NC];
                end else begin : g_out
                    assign nb[k] = 1'b0;
                end
`endif
            end

            always_comb begin
                sum = 4'd0;
                for (int k = 0; k < 8; k++) begin
                    sum = sum + {3'b000, nb[k]};
                end
            end

            assign nxt[r*COLS+c] = (sum == 4'd3) |
                                   ((sum == 4'd2) & grid_q[r*COLS+c]);
        end
    end

    assign timer_last = (timer_q == TW'(PERIOD - 1));
    assign no_change  = (nxt == grid_q);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        evolve  = 1'b0;
        if (load) begin
            state_d = IDLE;
            timer_d = '0;
        end else begin
            unique case (state_q)
                IDLE, HALT: begin
                    if (stop) begin
                        state_d = IDLE;
                    end else if (start) begin
                        state_d = RUN;
                        timer_d = '0;
                    end else if (step) begin
                        evolve = 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = IDLE;
                        timer_d = '0;
                    end else if (timer_last) begin
                        evolve  = 1'b1;
                        timer_d = '0;
                        if (STOP_ON_STABLE != 0 && no_change) begin
                            state_d = HALT;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grid_q   <= '0;
            gen_q    <= '0;
            done_q   <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            done_q <= evolve;
            if (load) begin
                grid_q   <= seed;
                gen_q    <= '0;
                stable_q <= 1'b0;
            end else if (evolve) begin
                grid_q   <= nxt;
                stable_q <= no_change;
                if (gen_q != '1) begin
                    gen_q <= gen_q + 1'b1;
                end
            end
        end
    end

    assign grid      = grid_q;
    assign gen_count = gen_q;
    assign running   = (state_q == RUN);
    assign gen_done  = done_q;
    assign stable    = stable_q;
    assign extinct   = ~|grid_q;

endmodule

// File: tb/tb_life_engine.sv
// Self-checking bench for life_engine (8x8, PERIOD=4, GEN_W=3).
// Reference model evaluates the Life rules with plain loops.
module tb_life_engine;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [63:0] seed;
    logic        start;
    logic        stop;
    logic        step;
    logic [63:0] grid;
    logic [2:0]  gen_count;
    logic        running;
    logic        gen_done;
    logic        stable;
    logic        extinct;

    int checks   = 0;
    int failures = 0;

    localparam logic [63:0] BLINK_H = (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28);
    localparam logic [63:0] BLINK_V = (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35);
    localparam logic [63:0] BLOCK   = (64'd1 << 0) | (64'd1 << 1) | (64'd1 << 8) | (64'd1 << 9);

    life_engine #(
        .ROWS(8), .COLS(8), .PERIOD(4), .GEN_W(3), .STOP_ON_STABLE(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .seed(seed),
        .start(start), .stop(stop), .step(step), .grid(grid),
        .gen_count(gen_count), .running(running), .gen_done(gen_done),
        .stable(stable), .extinct(extinct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] life_next(input logic [63:0] g);
        logic [63:0] n;
        logic [5:0]  ix;
        int cnt;
        int rr;
        int cc;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
`ifdef LIFE_TORUS_EN
                        rr = (rr + 8) % 8;
                        cc = (cc + 8) % 8;
`endif
                        if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8) begin
                            ix = 6'(rr * 8 + cc);
                            if (g[ix]) cnt++;
                        end
                    end
                end
                ix = 6'(r * 8 + c);
                n[ix] = (cnt == 3) || (cnt == 2 && g[ix]);
            end
        end
        return n;
    endfunction

    // Called at a negedge; applies inputs across one rising edge.
    task automatic drive(input bit l, input bit st, input bit sp,
                         input bit stp, input logic [63:0] sd);
        load  = l;
        start = st;
        stop  = sp;
        step  = stp;
        seed  = sd;
        @(negedge clk);
        load  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        step  = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        load = 0; start = 0; stop = 0; step = 0; seed = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (grid !== 64'd0 || gen_count !== 3'd0) begin
            failures++;
            $display("FAIL reset_grid got=%h/%0d exp=0/0", grid, gen_count);
        end
        checks++;
        if (running !== 1'b0 || gen_done !== 1'b0 || stable !== 1'b0 || extinct !== 1'b1) begin
            failures++;
            $display("FAIL reset_flags got=%b%b%b%b exp=0001", running, gen_done, stable, extinct);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (grid !== 64'd0 || running !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got=%h run=%b exp=0 run=0", grid, running);
        end
    endtask

    task automatic test_blinker;
        drive(1, 0, 0, 0, BLINK_H);
        drive(0, 0, 0, 1, '0);
        checks++;
        if (grid !== BLINK_V || gen_count !== 3'd1) begin
            failures++;
            $display("FAIL blinker_step1 got=%h/%0d exp=%h/1", grid, gen_count, BLINK_V);
        end
        checks++;
        if (gen_done !== 1'b1) begin
            failures++;
            $display("FAIL blinker_done got=%b exp=1", gen_done);
        end
        @(negedge clk);
        checks++;
        if (gen_done !== 1'b0) begin
            failures++;
            $display("FAIL blinker_done_pulse got=%b exp=0", gen_done);
        end
        drive(0, 0, 0, 1, '0);
        checks++;
        if (grid !== BLINK_H || gen_count !== 3'd2 || stable !== 1'b0) begin
            failures++;
            $display("FAIL blinker_step2 got=%h/%0d/%b exp=%h/2/0", grid, gen_count, stable, BLINK_H);
        end
    endtask

    task automatic test_border;
        logic [63:0] exp;
`ifdef LIFE_TORUS_EN
        exp = (64'd1 << 1) | (64'd1 << 9) | (64'd1 << 57);
`else
        exp = (64'd1 << 1) | (64'd1 << 9);
`endif
        drive(1, 0, 0, 0, 64'h7);
        drive(0, 0, 0, 1, '0);
        checks++;
        if (grid !== exp) begin
            failures++;
            $display("FAIL border got=%h exp=%h", grid, exp);
        end
    endtask

    task automatic test_block;
        drive(1, 0, 0, 0, BLOCK);
        drive(0, 1, 0, 0, '0);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (gen_count !== 3'd0 || gen_done !== 1'b0 || running !== 1'b1) begin
                failures++;
                $display("FAIL block_wait%0d got=%0d/%b/%b exp=0/0/1", i, gen_count, gen_done, running);
            end
        end
        @(negedge clk);
        checks++;
        if (grid !== BLOCK || gen_count !== 3'd1 || gen_done !== 1'b1) begin
            failures++;
            $display("FAIL block_evolve got=%h/%0d/%b exp=%h/1/1", grid, gen_count, gen_done, BLOCK);
        end
        checks++;
        if (stable !== 1'b1 || running !== 1'b0) begin
            failures++;
            $display("FAIL block_halt got=stable%b run%b exp=stable1 run0", stable, running);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] m;
        m = {$urandom, $urandom};
        drive(1, 0, 0, 0, m);
        step = 1'b1;
        repeat (3) @(negedge clk);
        step = 1'b0;
        m = life_next(life_next(life_next(m)));
        checks++;
        if (grid !== m || gen_count !== 3'd3) begin
            failures++;
            $display("FAIL b2b_step got=%h/%0d exp=%h/3", grid, gen_count, m);
        end
        @(negedge clk);
        checks++;
        if (gen_done !== 1'b0 || grid !== m) begin
            failures++;
            $display("FAIL b2b_idle got=%b/%h exp=0/%h", gen_done, grid, m);
        end
    endtask

    task automatic test_priority;
        logic [63:0] s;
        s = {$urandom, $urandom};
        drive(1, 0, 0, 0, BLINK_H);
        drive(0, 1, 0, 0, '0);
        repeat (3) @(negedge clk);
        drive(1, 1, 1, 1, s);
        checks++;
        if (grid !== s || gen_count !== 3'd0) begin
            failures++;
            $display("FAIL prio_load got=%h/%0d exp=%h/0", grid, gen_count, s);
        end
        checks++;
        if (running !== 1'b0 || gen_done !== 1'b0 || stable !== 1'b0) begin
            failures++;
            $display("FAIL prio_flags got=%b%b%b exp=000", running, gen_done, stable);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (grid !== s) begin
            failures++;
            $display("FAIL prio_idle got=%h exp=%h", grid, s);
        end
    endtask

    task automatic test_random_step;
        logic [63:0] m;
        logic [63:0] prev;
        for (int t = 0; t < 6; t++) begin
            m = {$urandom, $urandom};
            drive(1, 0, 0, 0, m);
            for (int k = 1; k <= 5; k++) begin
                drive(0, 0, 0, 1, '0);
                prev = m;
                m = life_next(m);
                checks++;
                if (grid !== m || gen_count !== 3'(k)) begin
                    failures++;
                    $display("FAIL rand_step t%0d k%0d got=%h/%0d exp=%h/%0d", t, k, grid, gen_count, m, k);
                end
                checks++;
                if (stable !== (m == prev) || extinct !== (m == 64'd0) || gen_done !== 1'b1) begin
                    failures++;
                    $display("FAIL rand_flags t%0d k%0d got=%b%b%b exp=%b%b1", t, k,
                             stable, extinct, gen_done, (m == prev), (m == 64'd0));
                end
            end
        end
    endtask

    task automatic test_run_random;
        logic [63:0] m;
        logic [63:0] prev;
        int gap;
        bit halted;
        for (int t = 0; t < 3; t++) begin
            m = {$urandom, $urandom} & {$urandom, $urandom};
            drive(1, 0, 0, 0, m);
            drive(0, 1, 0, 0, '0);
            gap = 0;
            halted = 0;
            for (int cyc = 0; cyc < 160 && !halted; cyc++) begin
                @(negedge clk);
                gap++;
                if (gen_done) begin
                    prev = m;
                    m = life_next(m);
                    checks++;
                    if (gap != 4 || grid !== m) begin
                        failures++;
                        $display("FAIL run_gen t%0d gap=%0d got=%h exp gap=4 %h", t, gap, grid, m);
                    end
                    checks++;
                    if (running !== (m != prev)) begin
                        failures++;
                        $display("FAIL run_halt t%0d got=%b exp=%b", t, running, (m != prev));
                    end
                    if (m == prev) halted = 1;
                    gap = 0;
                end
            end
            drive(0, 0, 1, 0, '0);
        end
    endtask

    task automatic test_saturation;
        logic [63:0] m;
        int n;
        m = BLINK_H;
        n = 0;
        drive(1, 0, 0, 0, m);
        drive(0, 1, 0, 0, '0);
        for (int cyc = 0; cyc < 100 && n < 10; cyc++) begin
            @(negedge clk);
            if (gen_done) begin
                n++;
                m = life_next(m);
            end
        end
        checks++;
        if (n != 10) begin
            failures++;
            $display("FAIL sat_timeout got=%0d gens exp=10", n);
        end
        checks++;
        if (gen_count !== 3'd7 || grid !== m || running !== 1'b1) begin
            failures++;
            $display("FAIL sat_count got=%0d/%h/%b exp=7/%h/1", gen_count, grid, running, m);
        end
        drive(0, 0, 1, 0, '0);
    endtask

    task automatic test_async_reset;
        drive(1, 0, 0, 0, BLINK_H);
        drive(0, 1, 0, 0, '0);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (grid !== 64'd0 || gen_count !== 3'd0 || running !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got=%h/%0d/%b exp=0/0/0", grid, gen_count, running);
        end
        checks++;
        if (extinct !== 1'b1 || gen_done !== 1'b0 || stable !== 1'b0) begin
            failures++;
            $display("FAIL async_flags got=%b%b%b exp=100", extinct, gen_done, stable);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (running !== 1'b0 || grid !== 64'd0) begin
            failures++;
            $display("FAIL async_after got=%b/%h exp=0/0", running, grid);
        end
    endtask

    initial begin
        test_reset();
        test_blinker();
        test_border();
        test_block();
        test_back_to_back();
        test_priority();
        test_random_step();
        test_run_random();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
